// File: rtl/regfile_sb.sv
`default_nettype none
// ============================================================================
//  Module   : regfile_sb
//  Purpose  : Two-read / two-write register file with a per-register busy
//             scoreboard. r0 reads as zero and is never written or busy.
//             Port M has write priority over port E.
//             Optional macro REGFILE_SB_BYPASS_EN forwards same-cycle write
//             data to the read ports (M > E > array).
//  Revision : 1.0 - initial release
// ============================================================================
module regfile_sb #(
    parameter int DW = 8,
    parameter int AW = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] srcA,
    input  logic [AW-1:0] srcB,
    output logic [DW-1:0] A,
    output logic [DW-1:0] B,
    output logic          A_busy,
    output logic          B_busy,
    input  logic [AW-1:0] dstM,
    input  logic [DW-1:0] M,
    input  logic [AW-1:0] dstE,
    input  logic [DW-1:0] E,
    input  logic          iss_en,
    input  logic [AW-1:0] iss_dst,
    output logic [AW:0]   busy_cnt
);

    localparam int NREG = 2**AW;

    logic [DW-1:0]   r_rf [NREG];
    logic [NREG-1:0] r_busy;
    logic [AW:0]     r_cnt;

    logic            w_wr_m;
    logic            w_wr_e;
    logic [NREG-1:0] w_busy_nxt;
    logic [AW:0]     w_cnt_nxt;
    logic            w_a_fwd_m;
    logic            w_a_fwd_e;
    logic            w_b_fwd_m;
    logic            w_b_fwd_e;

    // E is dropped when it collides with M, so only M updates that register
    assign w_wr_m = (dstM != '0);
    assign w_wr_e = (dstE != '0) && (dstE != dstM);

    // Next busy vector: writebacks clear first, then issue sets, so set wins
    always_comb begin
        w_busy_nxt = r_busy;
        if (w_wr_m) w_busy_nxt[dstM] = 1'b0;
        if (w_wr_e) w_busy_nxt[dstE] = 1'b0;
        if (iss_en) w_busy_nxt[iss_dst] = 1'b1;
        w_busy_nxt[0] = 1'b0;
    end

    // Popcount of the next busy vector; bounded by NREG-1 so it cannot wrap
    always_comb begin
        w_cnt_nxt = '0;
        for (int i = 1; i < NREG; i++) begin
            w_cnt_nxt = w_cnt_nxt + {{AW{1'b0}}, w_busy_nxt[i]};
        end
    end

    // Register storage; reset clears everything and overrides writes
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                r_rf[i] <= '0;
            end
        end else begin
            if (w_wr_m) r_rf[dstM] <= M;
            if (w_wr_e) r_rf[dstE] <= E;
        end
    end

    // Scoreboard state and its population count; reset discards pending issues
    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy <= '0;
            r_cnt  <= '0;
        end else begin
            r_busy <= w_busy_nxt;
            r_cnt  <= w_cnt_nxt;
        end
    end

`ifdef REGFILE_SB_BYPASS_EN
    assign w_a_fwd_m = w_wr_m && (srcA == dstM);
    assign w_a_fwd_e = (dstE != '0) && (srcA == dstE);
    assign w_b_fwd_m = w_wr_m && (srcB == dstM);
    assign w_b_fwd_e = (dstE != '0) && (srcB == dstE);
`else
    assign w_a_fwd_m = 1'b0;
    assign w_a_fwd_e = 1'b0;
    assign w_b_fwd_m = 1'b0;
    assign w_b_fwd_e = 1'b0;
`endif

    // Read port A: r0 is zero, forwarded data wins over the array
    always_comb begin
        A      = '0;
        A_busy = 1'b0;
        if (srcA != '0) begin
            if (w_a_fwd_m)      A = M;
            else if (w_a_fwd_e) A = E;
            else                A = r_rf[srcA];
            // A forwarded value is the result itself, so it is never busy
            A_busy = r_busy[srcA] && !(w_a_fwd_m || w_a_fwd_e);
        end
    end

    // Read port B: same rules as port A
    always_comb begin
        B      = '0;
        B_busy = 1'b0;
        if (srcB != '0) begin
            if (w_b_fwd_m)      B = M;
            else if (w_b_fwd_e) B = E;
            else                B = r_rf[srcB];
            B_busy = r_busy[srcB] && !(w_b_fwd_m || w_b_fwd_e);
        end
    end

    assign busy_cnt = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_regfile_sb.sv
`default_nettype none
// ============================================================================
//  Module   : tb_regfile_sb
//  Purpose  : Self-checking bench for regfile_sb: directed scenarios plus
//             randomized traffic compared against a behavioural model.
//             Honours REGFILE_SB_BYPASS_EN the same way as the design.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_sb;

    localparam int DW   = 8;
    localparam int AW   = 3;
    localparam int NREG = 2**AW;

    logic          clk;
    logic          rst;
    logic [AW-1:0] srcA, srcB, dstM, dstE, iss_dst;
    logic [DW-1:0] M, E, A, B;
    logic          A_busy, B_busy, iss_en;
    logic [AW:0]   busy_cnt;

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural model state
    int m_rf   [NREG];
    bit m_busy [NREG];

    regfile_sb #(.DW(DW), .AW(AW)) u_dut (
        .clk      (clk),
        .rst      (rst),
        .srcA     (srcA),
        .srcB     (srcB),
        .A        (A),
        .B        (B),
        .A_busy   (A_busy),
        .B_busy   (B_busy),
        .dstM     (dstM),
        .M        (M),
        .dstE     (dstE),
        .E        (E),
        .iss_en   (iss_en),
        .iss_dst  (iss_dst),
        .busy_cnt (busy_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int model_cnt();
        int c = 0;
        for (int r = 1; r < NREG; r++) c += m_busy[r] ? 1 : 0;
        return c;
    endfunction

    // Expected read data for an address given the currently driven writes
    function automatic int exp_data(input int sa);
        if (sa == 0) return 0;
`ifdef REGFILE_SB_BYPASS_EN
        if (sa == int'(dstM)) return int'(M);
        if (sa == int'(dstE)) return int'(E);
`endif
        return m_rf[sa];
    endfunction

    function automatic int exp_busy(input int sa);
        if (sa == 0) return 0;
`ifdef REGFILE_SB_BYPASS_EN
        if (sa == int'(dstM) || sa == int'(dstE)) return 0;
`endif
        return m_busy[sa] ? 1 : 0;
    endfunction

    task automatic drive(input bit r, input int sa, input int sb,
                         input int dm, input int mv, input int de, input int ev,
                         input bit ie, input int id);
        rst     = r;
        srcA    = AW'(sa);
        srcB    = AW'(sb);
        dstM    = AW'(dm);
        M       = DW'(mv);
        dstE    = AW'(de);
        E       = DW'(ev);
        iss_en  = ie;
        iss_dst = AW'(id);
        #1;
    endtask

    task automatic check_model();
        check("A",        int'(A),        exp_data(int'(srcA)));
        check("B",        int'(B),        exp_data(int'(srcB)));
        check("A_busy",   int'(A_busy),   exp_busy(int'(srcA)));
        check("B_busy",   int'(B_busy),   exp_busy(int'(srcB)));
        check("busy_cnt", int'(busy_cnt), model_cnt());
    endtask

    // Advance one clock edge and apply the same edge to the model
    task automatic cycle();
        @(posedge clk);
        if (rst) begin
            for (int r = 0; r < NREG; r++) begin
                m_rf[r]   = 0;
                m_busy[r] = 0;
            end
        end else begin
            if (dstM != 0) begin
                m_rf[dstM]   = int'(M);
                m_busy[dstM] = 0;
            end
            if (dstE != 0 && dstE != dstM) begin
                m_rf[dstE]   = int'(E);
                m_busy[dstE] = 0;
            end
            if (iss_en && iss_dst != 0) m_busy[iss_dst] = 1;
        end
        @(negedge clk);
    endtask

    // Drive, check against model, then clock
    task automatic step(input bit r, input int sa, input int sb,
                        input int dm, input int mv, input int de, input int ev,
                        input bit ie, input int id);
        drive(r, sa, sb, dm, mv, de, ev, ie, id);
        check_model();
        cycle();
    endtask

    // Idle look at a register
    task automatic look(input int sa);
        drive(0, sa, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        @(negedge clk);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        cycle();

        // Reset state
        look(3);
        check("reset_A", int'(A), 0);
        check("reset_cnt", int'(busy_cnt), 0);

        // Reset overrides a same-cycle write
        step(0, 3, 0, 3, 'h5A, 0, 0, 0, 0);
        look(3);
        check("wr_r3", int'(A), 'h5A);
        step(1, 3, 0, 3, 'hFF, 0, 0, 1, 4);
        look(3);
        check("rst_over_wr_A", int'(A), 0);
        check("rst_over_wr_cnt", int'(busy_cnt), 0);

        // r0 ignores writes; M wins collision
        step(0, 0, 0, 0, 'h11, 0, 0, 0, 0);
        look(0);
        check("r0_zero", int'(A), 0);
        step(0, 0, 0, 5, 'h22, 5, 'h33, 0, 0);
        look(5);
        check("collision_r5", int'(A), 'h22);

        // Scoreboard
        step(0, 2, 4, 0, 0, 0, 0, 1, 2);
        look(2);
        check("cnt_after_r2", int'(busy_cnt), 1);
        check("busy_r2", int'(A_busy), 1);
        step(0, 2, 4, 0, 0, 0, 0, 1, 4);
        check("cnt_after_r4", int'(busy_cnt), 2);
        step(0, 2, 4, 2, 'h44, 0, 0, 0, 0);
        look(2);
        check("cnt_after_wb", int'(busy_cnt), 1);
        check("wb_r2_A", int'(A), 'h44);
        check("wb_r2_busy", int'(A_busy), 0);

        // Set wins over clear in the same cycle
        step(0, 6, 0, 0, 0, 0, 0, 1, 6);
        look(6);
        check("r6_busy", int'(A_busy), 1);
        check("cnt_r6", int'(busy_cnt), 2);
        step(0, 6, 0, 0, 0, 6, 'h77, 1, 6);
        look(6);
        check("setwin_A", int'(A), 'h77);
        check("setwin_busy", int'(A_busy), 1);
        check("setwin_cnt", int'(busy_cnt), 2);

        // Same-cycle forwarding (or not, without the bypass)
        step(0, 7, 0, 7, 'h10, 0, 0, 0, 0);
        drive(0, 7, 0, 0, 0, 7, 'h99, 0, 0);
`ifdef REGFILE_SB_BYPASS_EN
        check("fwd_E", int'(A), 'h99);
`else
        check("nofwd_E", int'(A), 'h10);
`endif
        drive(0, 7, 0, 7, 'hAA, 7, 'h99, 0, 0);
`ifdef REGFILE_SB_BYPASS_EN
        check("fwd_M", int'(A), 'hAA);
`else
        check("nofwd_M", int'(A), 'h10);
`endif
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        cycle();

        // Saturation
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int r = 1; r < NREG; r++) step(0, r, 0, 0, 0, 0, 0, 1, r);
        look(7);
        check("sat_cnt", int'(busy_cnt), NREG - 1);
        step(0, 7, 0, 0, 0, 0, 0, 1, 7);
        look(7);
        check("sat_reissue_cnt", int'(busy_cnt), NREG - 1);

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            step(($urandom_range(0, 39) == 0),
                 $urandom_range(0, NREG - 1), $urandom_range(0, NREG - 1),
                 $urandom_range(0, NREG - 1), $urandom_range(0, 255),
                 $urandom_range(0, NREG - 1), $urandom_range(0, 255),
                 $urandom_range(0, 1) == 1, $urandom_range(0, NREG - 1));
        end
        look(0);
        check_model();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
